tc_operand_skewer: RTL and testbench

TC_OPERAND_SKEWER -- requirements
Module: tc_operand_skewer

---
 rtl/tc_operand_skewer.sv | 153 +++++++++++++++
 tb/tb_tc_operand_skewer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_operand_skewer.sv
// Operand skewer for an N x N systolic array: registers incoming A/B tile pairs,
// delays lane (i,j) by i+j stages (B transposed) and frames each burst with clear/valid/done.
module tc_operand_skewer #(
    parameter int N     = 8,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [WIDTH*N*N-1:0]    in_a,
    input  logic [WIDTH*N*N-1:0]    in_b,
    output logic [WIDTH*N*N-1:0]    out_a,
    output logic [WIDTH*N*N-1:0]    out_b,
    output logic                    out_valid,
    output logic                    clc_out,
    output logic                    done
);

    localparam int DRAIN_LAST = 2 * N - 2;
    localparam int CNT_W      = $clog2(2 * N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               out_valid_r;
    logic               out_valid_s;
    logic               done_r;
    logic               done_s;
    logic               clc_s;
    logic               accept_s;

    assign in_ready  = rst || (state_r != ST_DRAIN);
    assign accept_s  = in_valid && !rst && (state_r != ST_DRAIN);
    assign clc_out   = clc_s;
    assign out_valid = out_valid_r;
    assign done      = done_r;

    // Next-state, drain counter and framing decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        clc_s       = 1'b0;
        out_valid_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (accept_s) begin
                    clc_s       = 1'b1;
                    out_valid_s = 1'b1;
                    if (in_last) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_FEED;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                cnt_s       = {CNT_W{1'b0}};
                out_valid_s = 1'b1;
                if (accept_s && in_last) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                // Drain until the deepest lane (depth 2N-1) has emitted the last beat.
                if (cnt_r == CNT_W'(DRAIN_LAST)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    done_s  = 1'b1;
                end else begin
                    state_s     = ST_DRAIN;
                    cnt_s       = cnt_r + CNT_W'(1);
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
            done_r      <= done_s;
        end
    end

    // Per-lane delay lines; unaccepted cycles shift in zeros so lanes never hold stale data.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int D = gi + gj;
            logic [WIDTH-1:0]       a_in_s;
            logic [WIDTH-1:0]       b_in_s;
            logic [WIDTH*(D+1)-1:0] a_sh_r;
            logic [WIDTH*(D+1)-1:0] b_sh_r;

            assign a_in_s = accept_s ? in_a[WIDTH*(gi*N+gj) +: WIDTH] : {WIDTH{1'b0}};
            assign b_in_s = accept_s ? in_b[WIDTH*(gj*N+gi) +: WIDTH] : {WIDTH{1'b0}};

            if (D == 0) begin : g_d0
                // Lane (0,0): input register only.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_sh_r <= {WIDTH{1'b0}};
                        b_sh_r <= {WIDTH{1'b0}};
                    end else begin
                        a_sh_r <= a_in_s;
                        b_sh_r <= b_in_s;
                    end
                end
            end else begin : g_dn
                // Input register plus D shift stages; newest element enters the low slot.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_sh_r <= {(WIDTH*(D+1)){1'b0}};
                        b_sh_r <= {(WIDTH*(D+1)){1'b0}};
                    end else begin
                        a_sh_r <= {a_sh_r[WIDTH*D-1:0], a_in_s};
                        b_sh_r <= {b_sh_r[WIDTH*D-1:0], b_in_s};
                    end
                end
            end

            assign out_a[WIDTH*(gi*N+gj) +: WIDTH] = a_sh_r[WIDTH*D +: WIDTH];
            assign out_b[WIDTH*(gi*N+gj) +: WIDTH] = b_sh_r[WIDTH*D +: WIDTH];
        end
    end

endmodule

// File: tb/tb_tc_operand_skewer.sv
// Directed self-checking bench for tc_operand_skewer (N=8, WIDTH=8): reset, single tile,
// long burst, bubble injection, drain hold with back-to-back burst, reset during drain.
module tb_tc_operand_skewer;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int L  = N * N;
    localparam int TW = W * L;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [TW-1:0] in_a;
    logic [TW-1:0] in_b;
    logic [TW-1:0] out_a;
    logic [TW-1:0] out_b;
    logic          out_valid;
    logic          clc_out;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TW-1:0] beat_a [256];
    logic [TW-1:0] beat_b [256];

    always #5 clk = ~clk;

    tc_operand_skewer #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .clc_out   (clc_out),
        .done      (done)
    );

    task automatic clear_hist();
        for (int k = 0; k < 256; k++) begin
            beat_a[k] = '0;
            beat_b[k] = '0;
        end
    endtask

    // Drive one cycle's inputs and record what the bench expects to enter the pipeline.
    task automatic step(input logic r, input logic v, input logic l,
                        input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input bit acc, input int t);
        @(negedge clk);
        rst = r; in_valid = v; in_last = l; in_a = a; in_b = b;
        #1;
        beat_a[t] = acc ? a : '0;
        beat_b[t] = acc ? b : '0;
    endtask

    // Expected A port: lane (i,j) shows a[i][j] of the beat that entered at t-1-i-j.
    function automatic logic [TW-1:0] exp_a(input int t);
        logic [TW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = t - 1 - i - j;
                if (s >= 0) r[W*(i*N+j) +: W] = beat_a[s][W*(i*N+j) +: W];
            end
        return r;
    endfunction

    // Expected B port: lane (i,j) shows b[j][i] of the beat that entered at t-1-i-j.
    function automatic logic [TW-1:0] exp_b(input int t);
        logic [TW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = t - 1 - i - j;
                if (s >= 0) r[W*(i*N+j) +: W] = beat_b[s][W*(j*N+i) +: W];
            end
        return r;
    endfunction

    function automatic logic [TW-1:0] rnd_tile();
        logic [TW-1:0] r;
        for (int k = 0; k < L; k++) r[W*k +: W] = W'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, rnd_tile(), rnd_tile(), 1'b0, 0);
        for (int t = 1; t < 5; t++) begin
            step(t < 4, t < 4, 1'b0, rnd_tile(), rnd_tile(), 1'b0, t);
            n_checks += 6;
            if (out_a !== '0) begin n_fail++; $display("FAIL reset_out_a t=%0d got %h want 0", t, out_a); end
            if (out_b !== '0) begin n_fail++; $display("FAIL reset_out_b t=%0d got %h want 0", t, out_b); end
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid t=%0d got %b want 0", t, out_valid); end
            if (clc_out !== 1'b0) begin n_fail++; $display("FAIL reset_clc t=%0d got %b want 0", t, clc_out); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done t=%0d got %b want 0", t, done); end
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready t=%0d got %b want 1", t, in_ready); end
        end
    endtask

    task automatic test_single();
        logic [TW-1:0] ta, tb;
        logic ev, ed, ec, er;
        for (int k = 0; k < L; k++) begin
            ta[W*k +: W] = W'(k + 1);
            tb[W*k +: W] = W'(0 - (k + 1));
        end
        clear_hist();
        for (int t = 0; t <= 2*N + 2; t++) begin
            step(1'b0, t == 0, t == 0, (t == 0) ? ta : '0, (t == 0) ? tb : '0, t == 0, t);
            ev = (t >= 1) && (t <= 2*N - 1);
            ed = (t == 2*N);
            ec = (t == 0);
            er = !((t >= 1) && (t <= 2*N - 1));
            n_checks += 6;
            if (out_a !== exp_a(t)) begin n_fail++; $display("FAIL single_out_a t=%0d got %h want %h", t, out_a, exp_a(t)); end
            if (out_b !== exp_b(t)) begin n_fail++; $display("FAIL single_out_b t=%0d got %h want %h", t, out_b, exp_b(t)); end
            if (out_valid !== ev) begin n_fail++; $display("FAIL single_out_valid t=%0d got %b want %b", t, out_valid, ev); end
            if (done !== ed) begin n_fail++; $display("FAIL single_done t=%0d got %b want %b", t, done, ed); end
            if (clc_out !== ec) begin n_fail++; $display("FAIL single_clc t=%0d got %b want %b", t, clc_out, ec); end
            if (in_ready !== er) begin n_fail++; $display("FAIL single_in_ready t=%0d got %b want %b", t, in_ready, er); end
            if (t == 6) begin
                n_checks += 2;
                if (out_a[W*19 +: W] !== 8'd20) begin n_fail++; $display("FAIL single_lane23_a t=%0d got %0d want 20", t, out_a[W*19 +: W]); end
                if (out_b[W*19 +: W] !== 8'he5) begin n_fail++; $display("FAIL single_lane23_b t=%0d got %h want e5", t, out_b[W*19 +: W]); end
            end
            if (t == 5 || t == 7) begin
                n_checks++;
                if (out_a[W*19 +: W] !== 8'd0) begin n_fail++; $display("FAIL single_lane23_idle t=%0d got %0d want 0", t, out_a[W*19 +: W]); end
            end
        end
    endtask

    task automatic test_random_burst();
        logic ev, ed, ec, er;
        int vcount;
        vcount = 0;
        clear_hist();
        for (int t = 0; t <= 48; t++) begin
            if (t < 32) step(1'b0, 1'b1, t == 31, rnd_tile(), rnd_tile(), 1'b1, t);
            else        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, t);
            ev = (t >= 1) && (t <= 46);
            ed = (t == 47);
            ec = (t == 0);
            er = !((t >= 32) && (t <= 46));
            if (out_valid === 1'b1) vcount++;
            n_checks += 6;
            if (out_a !== exp_a(t)) begin n_fail++; $display("FAIL burst_out_a t=%0d got %h want %h", t, out_a, exp_a(t)); end
            if (out_b !== exp_b(t)) begin n_fail++; $display("FAIL burst_out_b t=%0d got %h want %h", t, out_b, exp_b(t)); end
            if (out_valid !== ev) begin n_fail++; $display("FAIL burst_out_valid t=%0d got %b want %b", t, out_valid, ev); end
            if (done !== ed) begin n_fail++; $display("FAIL burst_done t=%0d got %b want %b", t, done, ed); end
            if (clc_out !== ec) begin n_fail++; $display("FAIL burst_clc t=%0d got %b want %b", t, clc_out, ec); end
            if (in_ready !== er) begin n_fail++; $display("FAIL burst_in_ready t=%0d got %b want %b", t, in_ready, er); end
        end
        n_checks++;
        if (vcount != 46) begin n_fail++; $display("FAIL burst_valid_len got %0d want 46", vcount); end
    endtask

    task automatic test_bubble();
        logic ev, ed, er;
        int vcount;
        vcount = 0;
        clear_hist();
        for (int t = 0; t <= 22; t++) begin
            if (t == 2)     step(1'b0, 1'b0, 1'b0, rnd_tile(), rnd_tile(), 1'b0, t);
            else if (t < 5) step(1'b0, 1'b1, t == 4, rnd_tile(), rnd_tile(), 1'b1, t);
            else            step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, t);
            ev = (t >= 1) && (t <= 19);
            ed = (t == 20);
            er = !((t >= 5) && (t <= 19));
            if (out_valid === 1'b1) vcount++;
            n_checks += 5;
            if (out_a !== exp_a(t)) begin n_fail++; $display("FAIL bubble_out_a t=%0d got %h want %h", t, out_a, exp_a(t)); end
            if (out_b !== exp_b(t)) begin n_fail++; $display("FAIL bubble_out_b t=%0d got %h want %h", t, out_b, exp_b(t)); end
            if (out_valid !== ev) begin n_fail++; $display("FAIL bubble_out_valid t=%0d got %b want %b", t, out_valid, ev); end
            if (done !== ed) begin n_fail++; $display("FAIL bubble_done t=%0d got %b want %b", t, done, ed); end
            if (in_ready !== er) begin n_fail++; $display("FAIL bubble_in_ready t=%0d got %b want %b", t, in_ready, er); end
        end
        n_checks++;
        if (vcount != 19) begin n_fail++; $display("FAIL bubble_valid_len got %0d want 19", vcount); end
    endtask

    task automatic test_back_to_back();
        logic ev, ed, ec, er;
        clear_hist();
        for (int t = 0; t <= 34; t++) begin
            if (t < 2)       step(1'b0, 1'b1, t == 1, rnd_tile(), rnd_tile(), 1'b1, t);
            else if (t < 17) step(1'b0, 1'b1, 1'b1, rnd_tile(), rnd_tile(), 1'b0, t);
            else if (t == 17) step(1'b0, 1'b1, 1'b1, rnd_tile(), rnd_tile(), 1'b1, t);
            else             step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, t);
            ev = ((t >= 1) && (t <= 16)) || ((t >= 18) && (t <= 32));
            ed = (t == 17) || (t == 33);
            ec = (t == 0) || (t == 17);
            er = !(((t >= 2) && (t <= 16)) || ((t >= 18) && (t <= 32)));
            n_checks += 6;
            if (out_a !== exp_a(t)) begin n_fail++; $display("FAIL b2b_out_a t=%0d got %h want %h", t, out_a, exp_a(t)); end
            if (out_b !== exp_b(t)) begin n_fail++; $display("FAIL b2b_out_b t=%0d got %h want %h", t, out_b, exp_b(t)); end
            if (out_valid !== ev) begin n_fail++; $display("FAIL b2b_out_valid t=%0d got %b want %b", t, out_valid, ev); end
            if (done !== ed) begin n_fail++; $display("FAIL b2b_done t=%0d got %b want %b", t, done, ed); end
            if (clc_out !== ec) begin n_fail++; $display("FAIL b2b_clc t=%0d got %b want %b", t, clc_out, ec); end
            if (in_ready !== er) begin n_fail++; $display("FAIL b2b_in_ready t=%0d got %b want %b", t, in_ready, er); end
        end
    endtask

    task automatic test_reset_drain();
        logic ev;
        clear_hist();
        for (int t = 0; t <= 20; t++) begin
            if (t == 0) step(1'b0, 1'b1, 1'b1, rnd_tile(), rnd_tile(), 1'b1, t);
            else        step(t == 3, 1'b0, 1'b0, '0, '0, 1'b0, t);
            ev = (t >= 1) && (t <= 3);
            n_checks += 4;
            if (out_a !== exp_a(t)) begin n_fail++; $display("FAIL rstdrain_out_a t=%0d got %h want %h", t, out_a, exp_a(t)); end
            if (out_b !== exp_b(t)) begin n_fail++; $display("FAIL rstdrain_out_b t=%0d got %h want %h", t, out_b, exp_b(t)); end
            if (out_valid !== ev) begin n_fail++; $display("FAIL rstdrain_out_valid t=%0d got %b want %b", t, out_valid, ev); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL rstdrain_done t=%0d got %b want 0", t, done); end
            if (t == 3) clear_hist();
        end
        test_single();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
        clear_hist();
        test_reset();
        test_single();
        test_random_burst();
        test_bubble();
        test_back_to_back();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
